alu_issue_seq: RTL and testbench

//  Issue/writeback stage wrapped around the 8-bit add/subtract datapath (dut).
//  - Accepts 16-bit instructions on a valid/ready interface.
//  - Owns the four 8-bit operand registers that drive dut.data0..data3.
//  - Drives dut.opcode for each ADD/SUB.
//  - Captures dut.result/overflow back into a destination register and

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_seq_regfile.sv | 35 +++
 rtl/alu_issue_seq.sv | 151 +++++++++++++++
 tb/tb_alu_issue_seq.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU issue/writeback stage.
package alu_seq_pkg;

    localparam int unsigned DW   = 8;
    localparam int unsigned NREG = 4;

    typedef enum logic [1:0] {
        OpNop  = 2'b00,
        OpLoad = 2'b01,
        OpAdd  = 2'b10,
        OpSub  = 2'b11
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [1:0] dst;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [7:0] imm;
    } instr_t;

    typedef enum logic {
        StIdle = 1'b0,
        StExec = 1'b1
    } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// Four-entry operand register file: one write port, all entries read in parallel.
module alu_seq_regfile #(
    parameter int unsigned DW = alu_seq_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [1:0]    waddr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] rdata3
);
    import alu_seq_pkg::*;

    logic [DW-1:0] regs_q [NREG];

    // Register storage with single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata0 = regs_q[0];
    assign rdata1 = regs_q[1];
    assign rdata2 = regs_q[2];
    assign rdata3 = regs_q[3];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue/writeback stage around the add/subtract datapath: accepts instructions,
// owns the operand registers, holds the opcode during execution and writes the
// result back.
module alu_issue_seq #(
    parameter int unsigned DW          = alu_seq_pkg::DW,
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [DW-1:0]    data0,
    output logic [DW-1:0]    data1,
    output logic [DW-1:0]    data2,
    output logic [DW-1:0]    data3,
    output logic [4:0]       opcode,
    input  logic [DW-1:0]    alu_result,
    input  logic             alu_overflow,
    input  logic             clear_ovf,
    output logic             res_valid,
    output logic [DW-1:0]    res_data,
    output logic             res_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] op_count
);
    import alu_seq_pkg::*;

    localparam int unsigned EW = 4;

    instr_t           ins;
    state_e           state_q, state_d;
    logic [EW-1:0]    ecnt_q, ecnt_d;
    logic [1:0]       dst_q, dst_d;
    logic [4:0]       opcode_q, opcode_d;
    logic             res_valid_q, res_valid_d;
    logic [DW-1:0]    res_data_q, res_data_d;
    logic             res_ovf_q, res_ovf_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             cap_ovf;
    logic             rf_we;
    logic [1:0]       rf_waddr;
    logic [DW-1:0]    rf_wdata;

    assign ins = instr_t'(instr);
    // Gate with rst_n so nothing looks acceptable while reset is held.
    assign instr_ready = rst_n && (state_q == StIdle);

    alu_seq_regfile #(
        .DW(DW)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .rdata0(data0),
        .rdata1(data1),
        .rdata2(data2),
        .rdata3(data3)
    );

    // Next-state: instruction decode in IDLE, countdown and writeback in EXEC.
    always_comb begin
        state_d     = state_q;
        ecnt_d      = ecnt_q;
        dst_d       = dst_q;
        opcode_d    = opcode_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_ovf_d   = res_ovf_q;
        op_count_d  = op_count_q;
        cap_ovf     = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = ins.dst;
        rf_wdata    = DW'(ins.imm);
        unique case (state_q)
            StIdle: begin
                if (instr_valid && instr_ready) begin
                    unique case (ins.op)
                        OpNop: ;
                        OpLoad: begin
                            rf_we       = 1'b1;
                            res_valid_d = 1'b1;
                            res_data_d  = DW'(ins.imm);
                            res_ovf_d   = 1'b0;
                        end
                        OpAdd, OpSub: begin
                            opcode_d = {(ins.op == OpSub), ins.src_a, ins.src_b};
                            dst_d    = ins.dst;
                            ecnt_d   = EW'(EXEC_CYCLES - 1);
                            state_d  = StExec;
                        end
                    endcase
                end
            end
            StExec: begin
                if (ecnt_q == '0) begin
                    rf_we       = 1'b1;
                    rf_waddr    = dst_q;
                    rf_wdata    = alu_result;
                    res_valid_d = 1'b1;
                    res_data_d  = alu_result;
                    res_ovf_d   = alu_overflow;
                    cap_ovf     = alu_overflow;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = StIdle;
                end else begin
                    ecnt_d = ecnt_q - EW'(1);
                end
            end
        endcase
        // A capture in the same cycle as clear_ovf leaves the flag set.
        ovf_sticky_d = (ovf_sticky_q & ~clear_ovf) | cap_ovf;
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ecnt_q       <= '0;
            dst_q        <= '0;
            opcode_q     <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_ovf_q    <= 1'b0;
            ovf_sticky_q <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            ecnt_q       <= ecnt_d;
            dst_q        <= dst_d;
            opcode_q     <= opcode_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_ovf_q    <= res_ovf_d;
            ovf_sticky_q <= ovf_sticky_d;
            op_count_q   <= op_count_d;
        end
    end

    assign opcode     = opcode_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_ovf    = res_ovf_q;
    assign ovf_sticky = ovf_sticky_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Closed-loop bench: issue stage plus a behavioural add/subtract datapath,
// checked against a register-level reference model.
module tb_alu_issue_seq;

    localparam int EXEC_CYCLES = 3;
    localparam int CNT_W       = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             instr_valid;
    logic             instr_ready;
    logic [15:0]      instr;
    logic [7:0]       data0, data1, data2, data3;
    logic [4:0]       opcode;
    logic [7:0]       alu_result;
    logic             alu_overflow;
    logic             clear_ovf;
    logic             res_valid;
    logic [7:0]       res_data;
    logic             res_ovf;
    logic             ovf_sticky;
    logic [CNT_W-1:0] op_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [7:0] m_r [4];
    int         m_cnt;
    bit         m_sticky;

    always #5 clk = ~clk;

    alu_issue_seq #(
        .DW(8),
        .EXEC_CYCLES(EXEC_CYCLES),
        .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .opcode(opcode), .alu_result(alu_result), .alu_overflow(alu_overflow),
        .clear_ovf(clear_ovf), .res_valid(res_valid), .res_data(res_data),
        .res_ovf(res_ovf), .ovf_sticky(ovf_sticky), .op_count(op_count)
    );

    // Stand-in for the combinational add/subtract datapath.
    logic [7:0] dp_a, dp_b;
    always_comb begin
        dp_a = data0;
        dp_b = data0;
        case (opcode[3:2])
            2'd1: dp_a = data1;
            2'd2: dp_a = data2;
            2'd3: dp_a = data3;
            default: dp_a = data0;
        endcase
        case (opcode[1:0])
            2'd1: dp_b = data1;
            2'd2: dp_b = data2;
            2'd3: dp_b = data3;
            default: dp_b = data0;
        endcase
        alu_result = opcode[4] ? dp_a - dp_b : dp_a + dp_b;
        if (opcode[4]) alu_overflow = (dp_a[7] != dp_b[7]) && (alu_result[7] != dp_a[7]);
        else           alu_overflow = (dp_a[7] == dp_b[7]) && (alu_result[7] != dp_a[7]);
    end

    function automatic logic [15:0] mk(input int op, input int dst, input int sa, input int sb,
                                       input int imm);
        mk = {2'(op), 2'(dst), 2'(sa), 2'(sb), 8'(imm)};
    endfunction

    function automatic logic [7:0] reg_of(input logic [1:0] i);
        case (i)
            2'd0: return data0;
            2'd1: return data1;
            2'd2: return data2;
            default: return data3;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_cnt    = 0;
        m_sticky = 1'b0;
    endtask

    // Architectural effect of one instruction, using signed integer arithmetic.
    task automatic model_apply(input logic [15:0] ins, output logic [7:0] res, output bit ovf);
        int a, b, s;
        res = 8'h00;
        ovf = 1'b0;
        case (ins[15:14])
            2'b01: begin
                res = ins[7:0];
                m_r[ins[13:12]] = res;
            end
            2'b10, 2'b11: begin
                a = int'($signed(m_r[ins[11:10]]));
                b = int'($signed(m_r[ins[9:8]]));
                s = ins[14] ? a - b : a + b;
                ovf = (s > 127) || (s < -128);
                res = s[7:0];
                m_r[ins[13:12]] = res;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                if (ovf) m_sticky = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        instr_valid = 1'b0;
        clear_ovf = 1'b0;
        instr = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Issue one instruction and follow it to completion, checking against the model.
    task automatic do_op(input logic [15:0] ins, input bit clr_cap);
        logic [7:0] e_res;
        bit         e_ovf;
        logic [4:0] e_opc;
        int         guard;
        e_opc = {ins[14], ins[11:8]};
        if (clr_cap && ins[15]) m_sticky = 1'b0;
        model_apply(ins, e_res, e_ovf);
        @(negedge clk);
        instr_valid = 1'b1;
        instr = ins;
        guard = 0;
        while (!instr_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (!instr_ready) begin
            n_err++;
            $display("FAIL accept_timeout: ready=%b required 1", instr_ready);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        if (ins[15:14] == 2'b00) begin
            n_cmp++;
            if (res_valid !== 1'b0) begin
                n_err++;
                $display("FAIL nop_res_valid: got %b required 0", res_valid);
            end
        end else if (ins[15:14] == 2'b01) begin
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== e_res || res_ovf !== 1'b0 ||
                reg_of(ins[13:12]) !== e_res) begin
                n_err++;
                $display("FAIL load: got v=%b d=%h o=%b r=%h required v=1 d=%h o=0 r=%h",
                         res_valid, res_data, res_ovf, reg_of(ins[13:12]), e_res, e_res);
            end
        end else begin
            n_cmp++;
            if (opcode !== e_opc || instr_ready !== 1'b0) begin
                n_err++;
                $display("FAIL exec_entry: got opc=%b rdy=%b required opc=%b rdy=0",
                         opcode, instr_ready, e_opc);
            end
            for (int k = 1; k <= EXEC_CYCLES; k++) begin
                if (k == EXEC_CYCLES) clear_ovf = clr_cap;
                @(posedge clk);
                #1;
                clear_ovf = 1'b0;
                n_cmp++;
                if (k < EXEC_CYCLES) begin
                    if (res_valid !== 1'b0 || opcode !== e_opc) begin
                        n_err++;
                        $display("FAIL exec_hold: got v=%b opc=%b required v=0 opc=%b",
                                 res_valid, opcode, e_opc);
                    end
                end else begin
                    if (res_valid !== 1'b1 || res_data !== e_res || res_ovf !== e_ovf ||
                        reg_of(ins[13:12]) !== e_res || ovf_sticky !== m_sticky ||
                        op_count !== CNT_W'(m_cnt) || instr_ready !== 1'b1) begin
                        n_err++;
                        $display({"FAIL alu_done: got v=%b d=%h o=%b r=%h s=%b c=%0d rdy=%b ",
                                  "required v=1 d=%h o=%b r=%h s=%b c=%0d rdy=1"},
                                 res_valid, res_data, res_ovf, reg_of(ins[13:12]), ovf_sticky,
                                 op_count, instr_ready, e_res, e_ovf, e_res, m_sticky, m_cnt);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr_valid = 1'b0;
        clear_ovf = 1'b0;
        instr = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (instr_ready !== 1'b0 || {data0, data1, data2, data3} !== 32'h0 || opcode !== 5'h0 ||
            res_valid !== 1'b0 || res_data !== 8'h0 || res_ovf !== 1'b0 ||
            ovf_sticky !== 1'b0 || op_count !== '0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b regs=%h opc=%b v=%b d=%h o=%b s=%b c=%0d required 0",
                     instr_ready, {data0, data1, data2, data3}, opcode, res_valid, res_data,
                     res_ovf, ovf_sticky, op_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b required 1", instr_ready);
        end
    endtask

    task automatic test_add();
        do_op(mk(1, 0, 0, 0, 8'h05), 1'b0);
        do_op(mk(1, 1, 0, 0, 8'h03), 1'b0);
        do_op(mk(2, 2, 0, 1, 0), 1'b0);
        n_cmp++;
        if (res_data !== 8'h08 || res_ovf !== 1'b0 || data2 !== 8'h08 || opcode !== 5'b0_00_01) begin
            n_err++;
            $display("FAIL add_basic: got d=%h o=%b r2=%h opc=%b required d=08 o=0 r2=08 opc=00001",
                     res_data, res_ovf, data2, opcode);
        end
    endtask

    task automatic test_sub();
        do_op(mk(3, 3, 1, 0, 0), 1'b0);
        n_cmp++;
        if (res_data !== 8'hFE || res_ovf !== 1'b0 || data3 !== 8'hFE || opcode !== 5'b1_01_00) begin
            n_err++;
            $display("FAIL sub_basic: got d=%h o=%b r3=%h opc=%b required d=fe o=0 r3=fe opc=10100",
                     res_data, res_ovf, data3, opcode);
        end
    endtask

    task automatic test_overflow();
        do_op(mk(1, 0, 0, 0, 8'h7F), 1'b0);
        do_op(mk(1, 1, 0, 0, 8'h01), 1'b0);
        do_op(mk(2, 0, 0, 1, 0), 1'b0);
        n_cmp++;
        if (res_data !== 8'h80 || res_ovf !== 1'b1 || ovf_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_add: got d=%h o=%b s=%b required d=80 o=1 s=1",
                     res_data, res_ovf, ovf_sticky);
        end
        // Plain clear, then overflow again with clear_ovf on the capture edge.
        @(negedge clk);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        m_sticky = 1'b0;
        n_cmp++;
        if (ovf_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got %b required 0", ovf_sticky);
        end
        do_op(mk(1, 0, 0, 0, 8'h7F), 1'b0);
        do_op(mk(2, 0, 0, 1, 0), 1'b1);
        n_cmp++;
        if (ovf_sticky !== 1'b1 || res_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set_wins: got s=%b o=%b required s=1 o=1", ovf_sticky, res_ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] prog [3];
        logic [7:0]  exp_d [3];
        bit          exp_o [3];
        int          idx, got, ready_low;
        bit          take;
        apply_reset();
        do_op(mk(1, 0, 0, 0, $urandom_range(0, 255)), 1'b0);
        do_op(mk(1, 1, 0, 0, $urandom_range(0, 255)), 1'b0);
        prog[0] = mk(2, 2, 0, 1, 0);
        prog[1] = mk(2, 3, 2, 2, 0);
        prog[2] = mk(2, 0, 0, 3, 0);
        for (int i = 0; i < 3; i++) model_apply(prog[i], exp_d[i], exp_o[i]);
        idx = 0;
        got = 0;
        ready_low = 0;
        for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
            @(negedge clk);
            if (idx < 3) begin
                instr_valid = 1'b1;
                instr = prog[idx];
            end else begin
                instr_valid = 1'b0;
            end
            if (!instr_ready) ready_low++;
            if (res_valid && idx < 3) begin
                n_cmp++;
                if (instr_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_ready_on_result: got %b required 1", instr_ready);
                end
            end
            take = instr_valid && instr_ready;
            @(posedge clk);
            #1;
            if (take) idx++;
            if (res_valid) begin
                n_cmp++;
                if (res_data !== exp_d[got] || res_ovf !== exp_o[got]) begin
                    n_err++;
                    $display("FAIL b2b_result%0d: got d=%h o=%b required d=%h o=%b",
                             got, res_data, res_ovf, exp_d[got], exp_o[got]);
                end
                got++;
            end
        end
        instr_valid = 1'b0;
        n_cmp++;
        if (got != 3 || ready_low != 3 * EXEC_CYCLES || op_count !== CNT_W'(3) ||
            data0 !== m_r[0] || data2 !== m_r[2] || data3 !== m_r[3]) begin
            n_err++;
            $display("FAIL b2b_totals: got n=%0d low=%0d c=%0d r0=%h r2=%h r3=%h required n=3 low=%0d c=3 r0=%h r2=%h r3=%h",
                     got, ready_low, op_count, data0, data2, data3, 3 * EXEC_CYCLES,
                     m_r[0], m_r[2], m_r[3]);
        end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        for (int i = 0; i < 48; i++) begin
            ins = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 255));
            do_op(ins, ($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic test_reset_mid_exec();
        int seen;
        do_op(mk(1, 0, 0, 0, 8'h09), 1'b0);
        do_op(mk(1, 1, 0, 0, 8'h04), 1'b0);
        @(negedge clk);
        instr_valid = 1'b1;
        instr = mk(2, 2, 0, 1, 0);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (instr_ready !== 1'b0 || data2 !== 8'h00 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_exec_reset: got rdy=%b r2=%h v=%b required 0",
                     instr_ready, data2, res_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        for (int k = 0; k < EXEC_CYCLES + 4; k++) begin
            @(posedge clk);
            #1;
            if (res_valid) seen++;
        end
        n_cmp++;
        if (seen != 0 || data2 !== 8'h00 || op_count !== '0 || instr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abandoned_op: got pulses=%0d r2=%h c=%0d rdy=%b required 0 00 0 1",
                     seen, data2, op_count, instr_ready);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_mid_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
